// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding seven-segment decoders.
// Latency: done pulses BIN_W+1 clocks after start is accepted; outputs registered.
// Backpressure: none; start is ignored while busy, so the requester must wait for busy=0 (or the done cycle).
module bin_to_bcd_seq #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int          SW   = 4 * DIGITS;
   localparam int          CW   = $clog2(BIN_W + 1);
   localparam logic [31:0] MAXV = 32'(10 ** DIGITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t           state;
   logic [BIN_W-1:0] sh;        // binary shift register, MSB feeds the scratch
   logic [SW-1:0]    scr;       // BCD scratch
   logic [SW-1:0]    scr_adj;   // scratch after the add-3 correction
   logic [SW-1:0]    bcd_fmt;   // scratch with leading-zero blanking applied
   logic [CW-1:0]    cnt;       // bits still to shift
   logic             blank_r;
   logic             ovf_r;
   logic             in_ovf;
   logic             seen;

   // Range check on the incoming value, evaluated on the accepting edge
   assign in_ovf = 32'(bin_in) > MAXV;

   // Add 3 to every nibble that would reach 10 or more after the next doubling
   always_comb begin
      scr_adj = scr;
      for (int i = 0; i < DIGITS; i++) begin
         if (scr[4*i +: 4] >= 4'd5)
            scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      end
   end

   // Blank every digit above the most significant nonzero one; digit 0 always shown
   always_comb begin
      bcd_fmt = scr;
      seen    = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (scr[4*i +: 4] != 4'd0)
            seen = 1'b1;
         if (blank_r && !seen)
            bcd_fmt[4*i +: 4] = 4'hF;
      end
   end

   // Control FSM with registered busy/done/overflow/bcd_out
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         sh       <= '0;
         scr      <= '0;
         cnt      <= '0;
         blank_r  <= 1'b0;
         ovf_r    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         bcd_out  <= {DIGITS{4'hF}};
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sh      <= bin_in;
                  blank_r <= blank_lz;
                  ovf_r   <= in_ovf;
                  scr     <= '0;
                  cnt     <= CW'(BIN_W);
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               // carry out of the top nibble is dropped; overflow masks it anyway
               scr <= SW'({scr_adj, sh[BIN_W-1]});
               sh  <= sh << 1;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1))
                  state <= FINISH;
            end
            FINISH: begin
               overflow <= ovf_r;
               bcd_out  <= ovf_r ? {DIGITS{4'hF}} : bcd_fmt;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases, held-start streaming,
// random traffic and mid-conversion reset, scored against an arithmetic model.
module tb_bin_to_bcd_seq;

   localparam int BIN_W  = 14;
   localparam int DIGITS = 4;
   localparam int SW     = 4 * DIGITS;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic [BIN_W-1:0] bin_in;
   logic             blank_lz;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [SW-1:0]    bcd_out;

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .bin_in   (bin_in),
      .blank_lz (blank_lz),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .bcd_out  (bcd_out)
   );

   typedef struct {
      logic [SW-1:0] bcd;
      logic          ovf;
      int            due;
   } exp_t;

   exp_t          sb[$];
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   int            m_cnt = 0;
   logic [SW-1:0] hold_bcd;
   logic          hold_ovf;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference conversion from decimal arithmetic
   function automatic exp_t ref_conv(input int v, input bit bl);
      exp_t r;
      int   p;
      r.due = 0;
      if (v > 10 ** DIGITS - 1) begin
         r.bcd = '1;
         r.ovf = 1'b1;
      end else begin
         r.ovf = 1'b0;
         r.bcd = '0;
         p = 1;
         for (int i = 0; i < DIGITS; i++) begin
            if (bl && i > 0 && v < p)
               r.bcd[4*i +: 4] = 4'hF;
            else
               r.bcd[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // Model: accepts start when idle, pushes expected result with its due cycle
   always @(posedge clk or negedge reset_n) begin
      exp_t me;
      if (!reset_n) begin
         m_cnt    = 0;
         sb.delete();
         hold_bcd = '1;
         hold_ovf = 1'b0;
      end else begin
         cyc++;
         if (m_cnt > 0) begin
            m_cnt--;
         end else if (start) begin
            me     = ref_conv(int'(bin_in), blank_lz);
            me.due = cyc + BIN_W + 1;
            sb.push_back(me);
            m_cnt  = BIN_W + 1;
         end
      end
   end

   // Monitor: every cycle compares handshake and held outputs against the scoreboard
   always @(negedge clk) begin
      exp_t pe;
      bit   exp_done;
      bit   exp_busy;
      if (reset_n === 1'b1) begin
         exp_done = (sb.size() > 0) && (sb[0].due == cyc);
         exp_busy = (m_cnt > 0);
         if (exp_done) begin
            pe       = sb.pop_front();
            hold_bcd = pe.bcd;
            hold_ovf = pe.ovf;
         end
         total++;
         if (done !== exp_done || busy !== exp_busy || bcd_out !== hold_bcd || overflow !== hold_ovf) begin
            bad++;
            $display("FAIL cycle %0d: done=%b busy=%b bcd=%h ovf=%b, want done=%b busy=%b bcd=%h ovf=%b",
                     cyc, done, busy, bcd_out, overflow, exp_done, exp_busy, hold_bcd, hold_ovf);
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0 && m_cnt == 0)
            return;
      end
      total++;
      bad++;
      $display("FAIL wait_idle: got timeout want idle within 200 cycles");
   endtask

   task automatic conv(input int v, input bit bl, input logic [SW-1:0] eb, input logic eo, input string name);
      @(negedge clk);
      start    = 1'b1;
      bin_in   = BIN_W'(v);
      blank_lz = bl;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check({name, "_bcd"}, bcd_out, eb);
      check({name, "_ovf"}, SW'(overflow), SW'(eo));
   endtask

   initial begin
      int dn;
      reset_n  = 1'b1;
      start    = 1'b0;
      bin_in   = '0;
      blank_lz = 1'b0;

      // asynchronous reset mid-cycle
      #3 reset_n = 1'b0;
      #1;
      check("rst_bcd",  bcd_out, 16'hFFFF);
      check("rst_busy", SW'(busy), 16'h0);
      check("rst_done", SW'(done), 16'h0);
      check("rst_ovf",  SW'(overflow), 16'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      conv(1234,  0, 16'h1234, 1'b0, "basic_1234");
      conv(42,    1, 16'hFF42, 1'b0, "blank_42");
      conv(0,     1, 16'hFFF0, 1'b0, "blank_0");
      conv(1005,  1, 16'h1005, 1'b0, "blank_1005");
      conv(9999,  0, 16'h9999, 1'b0, "max_9999");
      conv(10000, 0, 16'hFFFF, 1'b1, "ovf_10000");
      conv(16383, 1, 16'hFFFF, 1'b1, "ovf_16383");
      conv(0,     0, 16'h0000, 1'b0, "zero_noblank");
      conv(7,     1, 16'hFFF7, 1'b0, "blank_7");

      // start held high, inputs changing every cycle
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 160; i++) begin
         bin_in   = BIN_W'($urandom_range(0, 16383));
         blank_lz = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      start = 1'b0;
      wait_idle();

      // random sparse traffic, including start pulses while busy
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       bin_in = BIN_W'($urandom_range(9990, 10010));
            1:       bin_in = BIN_W'($urandom_range(0, 120));
            default: bin_in = BIN_W'($urandom_range(0, 16383));
         endcase
         blank_lz = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // reset during the 7th shift cycle of a conversion
      @(negedge clk);
      start    = 1'b1;
      bin_in   = BIN_W'(5678);
      blank_lz = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_bcd",  bcd_out, 16'hFFFF);
      check("midrst_busy", SW'(busy), 16'h0);
      check("midrst_ovf",  SW'(overflow), 16'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      dn = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1)
            dn++;
      end
      check("midrst_no_done", SW'(dn), 16'h0);
      check("midrst_blank",   bcd_out, 16'hFFFF);
      conv(77, 0, 16'h0077, 1'b0, "after_rst_77");

      check("sb_empty", SW'(sb.size()), 16'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
